// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory interface: FSM states, R_W encoding
// and the memory-mapped device register addresses.
package lc3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic R_W_READ  = 1'b0;
    localparam logic R_W_WRITE = 1'b1;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    // True when a full 16-bit address hits one of the device registers.
    function automatic logic is_mmio(input logic [15:0] addr);
        return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port synchronous RAM, 2**AW words of DW bits, registered read data.
// Read data is captured only when re is high and held otherwise.
module lc3_mem_array #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // NOTE: the storage array has no reset; clearing thousands of words would
    // force it out of RAM macros into flops, and software never relies on it.
    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface stage: MAR/MDR, multi-cycle access FSM driven by
// MIO_EN/R_W, ready pulse mem_r and the main memory array.
// Optional build macro LC3_MMIO_EN adds the keyboard/display device registers
// at xFE00..xFE06; without it those addresses are plain aliased memory.
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int DATASIZE = 16,
    parameter int MEM_AW   = 12,
    parameter int LATENCY  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATASIZE-1:0] bus_in,
    input  logic                ld_mar,
    input  logic                ld_mdr,
    input  logic                mio_en,
    input  logic                r_w,
    output logic [DATASIZE-1:0] mar_out,
    output logic [DATASIZE-1:0] mdr_out,
    output logic                mem_r,
    input  logic [7:0]          kbd_data,
    input  logic                kbd_valid,
    output logic [7:0]          disp_data,
    output logic                disp_valid
);

    localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATASIZE-1:0] addr_q, addr_d;
    logic [DATASIZE-1:0] wdata_q, wdata_d;
    logic                op_q, op_d;
    logic [DATASIZE-1:0] mar_q, mar_d;
    logic [DATASIZE-1:0] mdr_q, mdr_d;
    logic                mem_r_q, mem_r_d;

    logic [DATASIZE-1:0] ram_rdata;
    logic [DATASIZE-1:0] rd_data;
    logic                dev_sel;
    logic                ram_we;
    logic                ram_re;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    // Access FSM next state plus MAR/MDR/ready next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        mem_r_d = 1'b0;
        mar_d   = ld_mar ? bus_in : mar_q;
        mdr_d   = mdr_q;

        if (ld_mdr && !mio_en) begin
            mdr_d = bus_in;
        end else if (ld_mdr && mio_en && state_q == ST_DONE && op_q == R_W_READ) begin
            mdr_d = rd_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (mio_en) begin
                    state_d = ST_BUSY;
                    addr_d  = mar_q;
                    wdata_d = mdr_q;
                    op_d    = r_w;
                    cnt_d   = CNT_START;
                end
            end
            ST_BUSY: begin
                if (!mio_en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    mem_r_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled before the edge.
    // Core state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= R_W_READ;
            mar_q   <= '0;
            mdr_q   <= '0;
            mem_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            mem_r_q <= mem_r_d;
        end
    end

    // Writes commit on the edge leaving DONE; reset in DONE discards them.
    assign ram_we = (state_q == ST_DONE) && (op_q == R_W_WRITE) && !reset && !dev_sel;
    assign ram_re = (state_q == ST_BUSY) && (state_d == ST_DONE);

    lc3_mem_array #(
        .AW (MEM_AW),
        .DW (DATASIZE)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q[MEM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

`ifdef LC3_MMIO_EN
    logic       kbd_ready_q, kbd_ready_d;
    logic [7:0] kbd_char_q, kbd_char_d;
    logic       disp_valid_q, disp_valid_d;
    logic [7:0] disp_data_q, disp_data_d;

    assign dev_sel = is_mmio(addr_q);

    // Read data source: device register or RAM.
    always_comb begin
        rd_data = ram_rdata;
        if (addr_q == DATASIZE'(KBSR_ADDR)) begin
            rd_data = {kbd_ready_q, {(DATASIZE-1){1'b0}}};
        end else if (addr_q == DATASIZE'(KBDR_ADDR)) begin
            rd_data = DATASIZE'({8'h00, kbd_char_q});
        end else if (addr_q == DATASIZE'(DSR_ADDR)) begin
            rd_data = {1'b1, {(DATASIZE-1){1'b0}}};
        end else if (addr_q == DATASIZE'(DDR_ADDR)) begin
            rd_data = '0;
        end
    end

    // Keyboard/display register updates; a new key wins over a KBDR-read clear.
    always_comb begin
        kbd_ready_d  = kbd_ready_q;
        kbd_char_d   = kbd_char_q;
        disp_valid_d = 1'b0;
        disp_data_d  = disp_data_q;
        if (state_q == ST_DONE) begin
            if (op_q == R_W_READ && addr_q == DATASIZE'(KBDR_ADDR)) begin
                kbd_ready_d = 1'b0;
            end
            if (op_q == R_W_WRITE && addr_q == DATASIZE'(DDR_ADDR)) begin
                disp_valid_d = 1'b1;
                disp_data_d  = wdata_q[7:0];
            end
        end
        if (kbd_valid) begin
            kbd_char_d  = kbd_data;
            kbd_ready_d = 1'b1;
        end
    end

    // Device registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_ready_q  <= 1'b0;
            kbd_char_q   <= 8'h00;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
        end else begin
            kbd_ready_q  <= kbd_ready_d;
            kbd_char_q   <= kbd_char_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
`else
    logic unused_mmio;

    assign dev_sel     = 1'b0;
    assign rd_data     = ram_rdata;
    assign disp_valid  = 1'b0;
    assign disp_data   = 8'h00;
    assign unused_mmio = ^{kbd_data, kbd_valid, addr_q[DATASIZE-1:MEM_AW]};
`endif

    assign mar_out = mar_q;
    assign mdr_out = mdr_q;
    assign mem_r   = mem_r_q;

endmodule

// File: doc/lc3_mem_if.md
Name: lc3_mem_if

Overview:
LC-3 memory interface stage that sits directly downstream of the bus-source multiplexers.
- Holds MAR and MDR, both loaded from the 16-bit bus that the gate/MARMUX muxes drive.
- Runs a multi-cycle memory access under control of the control FSM's MIO_EN and R_W lines.
- Returns the LC-3 ready signal R and drives MDR back toward the bus gate.
- Contains the word-addressed main memory array. Memory-mapped device registers are optional.

Parameters:
- DATASIZE, 16, width of bus, MAR, MDR and memory words.
- MEM_AW, 12, implemented memory address bits. MAR[MEM_AW-1:0] indexes memory; upper bits are ignored, so memory aliases.
- LATENCY, 4, cycles from access start to R assertion; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- bus_in  in  DATASIZE  processor bus value
- ld_mar  in  1  load MAR from bus_in
- ld_mdr  in  1  load MDR (source chosen by mio_en)
- mio_en  in  1  memory access enable; also selects memory as MDR source
- r_w  in  1  1 = write, 0 = read
- mar_out  out  DATASIZE  current MAR
- mdr_out  out  DATASIZE  current MDR
- mem_r  out  1  ready; registered, high exactly one cycle per completed access
- kbd_data  in  8  keyboard character
- kbd_valid  in  1  one-cycle strobe: kbd_data valid
- disp_data  out  8  display character
- disp_valid  out  1  one-cycle strobe: DDR written

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset sets MAR=0, MDR=0, mem_r=0, disp_valid=0, disp_data=0, KBSR/KBDR=0, state=IDLE. Memory contents are not reset.
- MAR: when ld_mar=1, MAR<=bus_in at the edge, in any state.
- MDR load, mio_en=0: when ld_mdr=1, MDR<=bus_in at the edge, in any state.
- MDR load, mio_en=1: when ld_mdr=1, MDR<=read data, but only at the edge that ends a mem_r=1 cycle of a read. At any other time ld_mdr is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY: taken when mio_en=1 is sampled at an edge (call it edge 0). At that edge the block latches addr_q=MAR, wdata_q=MDR, op_q=r_w, and sets cnt=LATENCY-1.
- BUSY: cnt decrements each edge. When cnt==0, the next edge moves to DONE and sets mem_r=1. So mem_r is high during the cycle after edge LATENCY.
- DONE: lasts one cycle.
  - For a write, memory[addr_q]<=wdata_q at the edge that leaves DONE.
  - For a read, data = memory[addr_q], delivered via the synchronous RAM read that is issued on entering DONE.
  - DONE always returns to IDLE and clears mem_r.
  - If mio_en is still 1 in IDLE, a new access starts at that edge, so back-to-back accesses are allowed.
- Latched access fields: changes to r_w, MAR or MDR during BUSY/DONE do not affect the in-flight access.
- Abort: mio_en=0 sampled in BUSY returns the FSM to IDLE. No write happens and mem_r stays 0.
- Reset mid-access behaves like an abort. Any pending write is discarded.

Optional Feature:
LC3_MMIO_EN
- Enabled: full 16-bit addr_q is decoded for device registers, which bypass memory but use the same LATENCY handshake.
  - xFE00 KBSR: read value {ready,15'b0}.
  - xFE02 KBDR: read value {8'b0,kbd_char}. A completed KBDR read clears ready.
  - kbd_valid=1 latches kbd_data into kbd_char and sets ready; this takes priority over a same-cycle clear.
  - xFE04 DSR: reads x8000.
  - xFE06 DDR: a write pulses disp_valid for one cycle on the edge leaving DONE, with disp_data=wdata_q[7:0].
  - Writes to KBSR, KBDR or DSR are ignored.
- Disabled: these addresses are ordinary (aliased) memory, kbd inputs are ignored, and disp_valid=0, disp_data=0 constantly.

Decomposition:
- Package lc3_pkg:
  - FSM state encoding
  - R_W_READ/R_W_WRITE constants
  - MMIO address constants KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR
- Sub-module lc3_mem_array: single-port synchronous RAM, 2**MEM_AW x DATASIZE, with write enable and registered read data. Top-level lc3_mem_if instantiates it.

Test Plan:
- Reset, then idle: mar_out=x0000, mdr_out=x0000, mem_r=0 for 10 cycles.
- Write/read round trip, LATENCY=4:
  - Load MAR=x0030 and MDR=x1234 via the bus, then mio_en=1, r_w=1.
  - Required: mem_r high exactly one cycle, 4 cycles after the start edge.
  - Then read x0030 with ld_mdr asserted in the R cycle. Required: mdr_out=x1234 on the next cycle.
- In-flight immunity: change MAR to x0031 and r_w to 0 during BUSY of a write of x5555 to x0030. Required: x0030 holds x5555 and x0031 is unchanged.
- Abort and reset:
  - Drop mio_en in BUSY cycle 2: no mem_r, target location unchanged.
  - Assert reset in BUSY: state IDLE, mem_r=0, MAR=MDR=0.
- Aliasing: with MEM_AW=12, write xBEEF to x1005, then read x0005. Required: xBEEF.
- LC3_MMIO_EN:
  - kbd_valid with kbd_data=x41, then read xFE00. Required: x8000.
  - Read xFE02. Required: x0041.
  - Read xFE00 again. Required: x0000.
  - Write x0042 to xFE06. Required: disp_valid one cycle, disp_data=x42.
